// File: rtl/hazard_ctrl_pkg.sv
// Shared decode definitions for the hazard controller: opcodes, FSM states,
// instruction field slices and per-opcode register-usage classification.
package hazard_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_XOR    = 4'd2,
        OP_RED    = 4'd3,
        OP_SLL    = 4'd4,
        OP_SRA    = 4'd5,
        OP_ROR    = 4'd6,
        OP_PADDSB = 4'd7,
        OP_LW     = 4'd8,
        OP_SW     = 4'd9,
        OP_LLB    = 4'd10,
        OP_LHB    = 4'd11,
        OP_B      = 4'd12,
        OP_BR     = 4'd13,
        OP_PCS    = 4'd14,
        OP_HLT    = 4'd15
    } opcode_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DSTALL = 2'd1,
        ST_HALTED = 2'd2
    } hc_state_t;

    typedef struct packed {
        opcode_t    op;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       dest;     // writes a register other than R0
        logic       flag_set;
        logic       use_rs;
        logic       use_rt;
        logic       use_rd;
    } dec_t;

    function automatic opcode_t f_op(input logic [15:0] inst);
        return opcode_t'(inst[15:12]);
    endfunction

    function automatic logic [3:0] f_rd(input logic [15:0] inst);
        return inst[11:8];
    endfunction

    function automatic logic [3:0] f_rs(input logic [15:0] inst);
        return inst[7:4];
    endfunction

    function automatic logic [3:0] f_rt(input logic [15:0] inst);
        return inst[3:0];
    endfunction

    function automatic logic is_writer(input opcode_t op);
        return !(op inside {OP_SW, OP_B, OP_BR, OP_HLT});
    endfunction

    function automatic logic is_flagset(input opcode_t op);
        return op inside {OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR};
    endfunction

    function automatic logic reads_rs(input opcode_t op);
        return op inside {OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB,
                          OP_SLL, OP_SRA, OP_ROR, OP_LW, OP_SW, OP_BR};
    endfunction

    function automatic logic reads_rt(input opcode_t op);
        return op inside {OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB};
    endfunction

    function automatic logic reads_rd(input opcode_t op);
        return op inside {OP_SW, OP_LLB, OP_LHB};
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage instructions and
// resolution/miss inputs in, register enables, flushes and counters out.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [15:0]      ifid_inst;
    logic             ifid_valid;
    logic [15:0]      idex_inst;
    logic             idex_valid;
    logic [15:0]      exmem_inst;
    logic             exmem_valid;
    logic             branch_taken;
    logic             icache_stall;
    logic             dcache_stall;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ifid_inst, ifid_valid, idex_inst, idex_valid, exmem_inst, exmem_valid,
               branch_taken, icache_stall, dcache_stall,
        input  pc_write, ifid_write, idex_write, ifid_flush, idex_flush, halted,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  ifid_inst, ifid_valid, idex_inst, idex_valid, exmem_inst, exmem_valid,
               branch_taken, icache_stall, dcache_stall,
        output pc_write, ifid_write, idex_write, ifid_flush, idex_flush, halted,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_hz_decode.sv
// Combinational source/destination decode of a single pipeline instruction.
module hz_decode
    import hazard_ctrl_pkg::*;
(
    input  logic [15:0] inst,
    output dec_t        dec
);
    always_comb begin
        dec          = '0;
        dec.op       = f_op(inst);
        dec.rd       = f_rd(inst);
        dec.rs       = f_rs(inst);
        dec.rt       = f_rt(inst);
        dec.dest     = is_writer(dec.op) && (dec.rd != '0);
        dec.flag_set = is_flagset(dec.op);
        dec.use_rs   = reads_rs(dec.op);
        dec.use_rt   = reads_rt(dec.op);
        dec.use_rd   = reads_rd(dec.op);
    end
endmodule

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: load-use and branch-operand
// stalls, taken-branch flush, data-miss freeze, halt, and stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    dec_t       id_d;
    dec_t       ex_d;
    dec_t       mem_d;
    hc_state_t  state;
    logic       pend_br;
    logic       halted_q;
    logic       lu;
    logic       bf;
    logic       brr;
    logic       haz;
    logic       br_flush;
    logic       halt_go;
    logic       stall_evt;
    logic       flush_evt;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic       unused_ok;

    hz_decode u_dec_id  (.inst(bus.ifid_inst),  .dec(id_d));
    hz_decode u_dec_ex  (.inst(bus.idex_inst),  .dec(ex_d));
    hz_decode u_dec_mem (.inst(bus.exmem_inst), .dec(mem_d));

    assign unused_ok = ^{id_d.dest, id_d.flag_set, ex_d.rs, ex_d.rt, ex_d.use_rs,
                         ex_d.use_rt, ex_d.use_rd, mem_d.rs, mem_d.rt, mem_d.dest,
                         mem_d.flag_set, mem_d.use_rs, mem_d.use_rt, mem_d.use_rd};

    // A store whose only overlap with the load is its data register (rd) gets
    // the value forwarded later, so rd only counts for non-store readers.
    always_comb begin
        lu  = bus.idex_valid && (ex_d.op == OP_LW) && (ex_d.rd != '0) &&
              ((id_d.use_rs && (id_d.rs == ex_d.rd)) ||
               (id_d.use_rt && (id_d.rt == ex_d.rd)) ||
               (id_d.use_rd && (id_d.op != OP_SW) && (id_d.rd == ex_d.rd)));
        bf  = bus.idex_valid && (id_d.op == OP_B) && ex_d.flag_set;
        brr = (id_d.op == OP_BR) && (id_d.rs != '0) &&
              ((bus.idex_valid && ex_d.dest && (ex_d.rd == id_d.rs)) ||
               (bus.exmem_valid && (mem_d.op == OP_LW) && (mem_d.rd == id_d.rs)));
        haz = bus.ifid_valid && (lu || bf || brr);
    end

    assign br_flush = bus.branch_taken || pend_br;
    assign halt_go  = (state != ST_HALTED) && !bus.dcache_stall && bus.ifid_valid &&
                      (id_d.op == OP_HLT) && !haz && !br_flush;

    always_comb begin
        bus.pc_write   = 1'b1;
        bus.ifid_write = 1'b1;
        bus.idex_write = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        stall_evt      = 1'b0;
        flush_evt      = 1'b0;
        if (rst) begin
            stall_evt = 1'b0;
        end else if (bus.dcache_stall) begin
            bus.pc_write   = 1'b0;
            bus.ifid_write = 1'b0;
            bus.idex_write = 1'b0;
        end else if (state == ST_HALTED) begin
            bus.pc_write   = 1'b0;
            bus.ifid_flush = 1'b1;
        end else if (haz) begin
            bus.pc_write   = 1'b0;
            bus.ifid_write = 1'b0;
            bus.idex_flush = 1'b1;
            stall_evt      = 1'b1;
        end else if (br_flush) begin
            bus.ifid_flush = 1'b1;
            flush_evt      = 1'b1;
        end else if (bus.icache_stall) begin
            bus.pc_write   = 1'b0;
            bus.ifid_flush = 1'b1;
        end
    end

    // The cycle dcache_stall drops is evaluated as RUN, so DSTALL can exit
    // straight to HALTED when a HLT is waiting in ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            pend_br  <= 1'b0;
            halted_q <= 1'b0;
        end else if (state != ST_HALTED) begin
            if (bus.dcache_stall) begin
                state <= ST_DSTALL;
                if (bus.branch_taken && !haz)
                    pend_br <= 1'b1;
            end else begin
                if (flush_evt)
                    pend_br <= 1'b0;
                if (halt_go) begin
                    state    <= ST_HALTED;
                    halted_q <= 1'b1;
                end else begin
                    state <= ST_RUN;
                end
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(stall_evt), .count(stall_q));
    sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(flush_evt), .count(flush_q));

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a behavioural model predicts every cycle's
// enables, flushes, halt flag and counters; directed cases pin key values.
module tb_hazard_ctrl;
    logic clk;
    logic rst;
    int unsigned checks;
    int unsigned failures;

    typedef struct packed {
        logic        pc_w;
        logic        ifid_w;
        logic        idex_w;
        logic        ifid_f;
        logic        idex_f;
        logic        halted;
        logic [15:0] scnt;
        logic [15:0] fcnt;
    } exp_t;

    exp_t sb[$];

    logic        m_halt;
    logic        m_pend;
    logic [15:0] m_scnt;
    logic [15:0] m_fcnt;

    hazard_ctrl_if #(.CNT_W(16)) bus ();

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_haz(input logic [15:0] id, input bit idv,
                                     input logic [15:0] ex, input bit exv,
                                     input logic [15:0] mem, input bit memv);
        logic [3:0] iop;
        logic [3:0] eop;
        logic [3:0] erd;
        logic [3:0] irs;
        bit lu;
        bit bf;
        bit brr;
        iop = id[15:12];
        eop = ex[15:12];
        erd = ex[11:8];
        irs = id[7:4];
        lu  = 1'b0;
        if (exv && eop == 4'd8 && erd != 4'd0) begin
            case (iop)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd7: lu = (irs == erd) || (id[3:0] == erd);
                4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd13: lu = (irs == erd);
                4'd10, 4'd11: lu = (id[11:8] == erd);
                default: lu = 1'b0;
            endcase
        end
        bf  = (iop == 4'd12) && exv && (eop inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6});
        brr = (iop == 4'd13) && (irs != 4'd0) &&
              ((exv && !(eop inside {4'd9, 4'd12, 4'd13, 4'd15}) && erd == irs) ||
               (memv && mem[15:12] == 4'd8 && mem[11:8] == irs));
        return idv && (lu || bf || brr);
    endfunction

    task automatic step(input logic [15:0] id, input bit idv, input logic [15:0] ex, input bit exv,
                        input logic [15:0] mem, input bit memv, input bit bt, input bit ic,
                        input bit dc, input bit r);
        exp_t e;
        bit   h;
        @(posedge clk);
        #1;
        rst              = r;
        bus.ifid_inst    = id;
        bus.ifid_valid   = idv;
        bus.idex_inst    = ex;
        bus.idex_valid   = exv;
        bus.exmem_inst   = mem;
        bus.exmem_valid  = memv;
        bus.branch_taken = bt;
        bus.icache_stall = ic;
        bus.dcache_stall = dc;
        h = model_haz(id, idv, ex, exv, mem, memv);
        e = '{pc_w: 1'b1, ifid_w: 1'b1, idex_w: 1'b1, ifid_f: 1'b0, idex_f: 1'b0,
              halted: m_halt, scnt: m_scnt, fcnt: m_fcnt};
        if (r) begin
            e.pc_w = 1'b1;
        end else if (dc) begin
            e.pc_w = 1'b0; e.ifid_w = 1'b0; e.idex_w = 1'b0;
        end else if (m_halt) begin
            e.pc_w = 1'b0; e.ifid_f = 1'b1;
        end else if (h) begin
            e.pc_w = 1'b0; e.ifid_w = 1'b0; e.idex_f = 1'b1;
        end else if (bt || m_pend) begin
            e.ifid_f = 1'b1;
        end else if (ic) begin
            e.pc_w = 1'b0; e.ifid_f = 1'b1;
        end
        sb.push_back(e);

        @(negedge clk);
        e = sb.pop_front();
        check("pc_write",   bus.pc_write,   e.pc_w);
        check("ifid_write", bus.ifid_write, e.ifid_w);
        check("idex_write", bus.idex_write, e.idex_w);
        check("ifid_flush", bus.ifid_flush, e.ifid_f);
        check("idex_flush", bus.idex_flush, e.idex_f);
        check("halted",     bus.halted,     e.halted);
        check("stall_cnt",  bus.stall_cnt,  e.scnt);
        check("flush_cnt",  bus.flush_cnt,  e.fcnt);

        if (r) begin
            m_halt = 1'b0; m_pend = 1'b0; m_scnt = '0; m_fcnt = '0;
        end else if (!m_halt) begin
            if (dc) begin
                if (bt && !h) m_pend = 1'b1;
            end else if (h) begin
                if (m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
            end else if (bt || m_pend) begin
                if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
                m_pend = 1'b0;
            end else if (idv && id[15:12] == 4'hF) begin
                m_halt = 1'b1;
            end
        end
    endtask

    task automatic idle(input bit r);
        step(16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, r);
    endtask

    initial begin
        logic [15:0]  ri;
        logic [15:0]  rx;
        logic [15:0]  rm;
        int unsigned  tmp;
        checks   = 0;
        failures = 0;
        m_halt = 1'b0; m_pend = 1'b0; m_scnt = '0; m_fcnt = '0;
        rst = 1'b1;
        bus.ifid_inst = '0; bus.ifid_valid = 1'b0; bus.idex_inst = '0; bus.idex_valid = 1'b0;
        bus.exmem_inst = '0; bus.exmem_valid = 1'b0; bus.branch_taken = 1'b0;
        bus.icache_stall = 1'b0; bus.dcache_stall = 1'b0;

        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        check("rst_stall_cnt", bus.stall_cnt, 0);
        check("rst_halted", bus.halted, 0);

        // load-use: LW R3 in EX, ADD R4,R3,R5 in ID
        step(16'h0435, 1, 16'h8310, 1, 16'h0000, 0, 0, 0, 0, 0);
        check("lu_pc_write", bus.pc_write, 0);
        check("lu_ifid_write", bus.ifid_write, 0);
        check("lu_idex_flush", bus.idex_flush, 1);
        step(16'h0435, 1, 16'h8310, 0, 16'h8310, 1, 0, 0, 0, 0);
        check("lu_released", bus.pc_write, 1);
        check("lu_stall_cnt", bus.stall_cnt, 1);

        // store data match only: no stall; address match and LLB rd: stall
        step(16'h9360, 1, 16'h8310, 1, 16'h0000, 0, 0, 0, 0, 0);
        check("sw_data_pc_write", bus.pc_write, 1);
        check("sw_data_ifid_write", bus.ifid_write, 1);
        step(16'h9530, 1, 16'h8310, 1, 16'h0000, 0, 0, 0, 0, 0);
        step(16'hA305, 1, 16'h8310, 1, 16'h0000, 0, 0, 0, 0, 0);

        // flag hazard on B: stall first (branch ignored), flush next cycle
        step(16'hC000, 1, 16'h1123, 1, 16'h0000, 0, 1, 0, 0, 0);
        check("bf_no_flush", bus.ifid_flush, 0);
        step(16'hC000, 1, 16'h1123, 0, 16'h1123, 1, 1, 0, 0, 0);
        check("bf_flush", bus.ifid_flush, 1);
        idle(1'b0);
        check("bf_flush_cnt", bus.flush_cnt, 1);

        // BR operand hazards against EX writer and MEM load; R0 never hazards
        step(16'hD020, 1, 16'h0211, 1, 16'h0000, 0, 0, 0, 0, 0);
        step(16'hD020, 1, 16'h0000, 0, 16'h8210, 1, 0, 0, 0, 0);
        step(16'hD020, 1, 16'h0211, 0, 16'h8210, 0, 0, 0, 0, 0);
        step(16'hD000, 1, 16'h0011, 1, 16'h8010, 1, 0, 0, 0, 0);
        step(16'h0405, 1, 16'h8010, 1, 16'h0000, 0, 0, 0, 0, 0);
        check("lw_r0_no_stall", bus.pc_write, 1);

        // data miss with a branch taken in its first cycle
        step(16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 0);
        check("dc_freeze", bus.idex_write, 0);
        step(16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 0);
        step(16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 0);
        step(16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0);
        check("dc_release_flush", bus.ifid_flush, 1);

        step(16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 1, 0, 0);

        for (int i = 0; i < 300; i++) begin
            ri = 16'($urandom);
            rx = 16'($urandom);
            rm = 16'($urandom);
            ri = ri & 16'hF333;
            rx = rx & 16'hF333;
            rm = rm & 16'hF333;
            if (ri[15:12] == 4'hF) ri[15:12] = 4'h0;
            step(ri, 1'($urandom), rx, 1'($urandom), rm, 1'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 5) == 0), 1'b0);
        end

        // halt, drain, then reset
        idle(1'b0);
        step(16'hF000, 1, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 0);
        idle(1'b0);
        check("hlt_halted", bus.halted, 1);
        check("hlt_pc_write", bus.pc_write, 0);
        step(16'h0435, 1, 16'h8310, 1, 16'h0000, 0, 1, 0, 0, 0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        check("post_rst_halted", bus.halted, 0);
        check("post_rst_flush_cnt", bus.flush_cnt, 0);

        // reset in the middle of a data-miss freeze
        step(16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 1, 0);
        step(16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 1, 1);
        idle(1'b0);
        check("rst_mid_stall_run", bus.pc_write, 1);

        // saturate the stall counter with back-to-back load-use stalls
        step(16'h0435, 1, 16'h8310, 1, 16'h0000, 0, 0, 0, 0, 0);
        repeat (65540) @(posedge clk);
        tmp = 32'(m_scnt) + 32'd65540;
        m_scnt = (tmp > 32'd65535) ? 16'hFFFF : tmp[15:0];
        step(16'h0435, 1, 16'h8310, 1, 16'h0000, 0, 0, 0, 0, 0);
        check("stall_cnt_sat", bus.stall_cnt, 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
